// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter
//   Shares the single GPIO register port (BUSW / BUSWDATA / BUSRDATA / REGSEL)
//   among NREQ requesters. One requester is granted per IDLE cycle, its command
//   is sequenced onto the GPIO port (ISSUE, plus CAPTURE for reads) and a
//   one-cycle ack with read data / error is returned in RESP.
//
//   Optional feature macro: GPIO_ARB_FIXED_PRI_EN
//     defined   -> fixed priority, lowest index wins
//     undefined -> round-robin starting after the last granted requester
//
//   Every output is driven from a register. Reset is synchronous, active high.

module gpio_bus_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     we,
  input  logic [2*NREQ-1:0]   sel,
  input  logic [8*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]     ack,
  output logic [7:0]          rdata,
  output logic                err,
  output logic                busy,
  output logic [2:0]          gnt_id,
  output logic                gpio_busw,
  output logic [1:0]          gpio_regsel,
  output logic [7:0]          gpio_wdata,
  input  logic [7:0]          gpio_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t              state_r;
  logic                cmd_we_r;
  logic [1:0]          cmd_sel_r;

  logic [2:0]          win_s;
  logic                any_req_s;
  logic [NREQ-1:0]     we_sh_s;
  logic [2*NREQ-1:0]   sel_sh_s;
  logic [8*NREQ-1:0]   wdata_sh_s;
  logic                win_we_s;
  logic [1:0]          win_sel_s;
  logic [7:0]          win_wdata_s;
  logic [NREQ-1:0]     grant_oh_s;
  logic                wr_err_s;

`ifdef GPIO_ARB_FIXED_PRI_EN
  // Lowest requesting index wins; scanning downwards lets the lowest overwrite.
  function automatic logic [2:0] fixed_pick(input logic [NREQ-1:0] r);
    logic [2:0]      pick;
    logic [NREQ-1:0] rot;
    pick = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rot  = r >> k;
      pick = rot[0] ? 3'(k) : pick;
    end
    return pick;
  endfunction
`else
  logic [2:0] last_gnt_r;

  // Search starts at last+1 and wraps; scanning from the farthest candidate
  // towards the nearest lets the nearest requester overwrite the pick.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r,
                                         input logic [2:0]      last);
    logic [2:0]      pick;
    logic [NREQ-1:0] rot;
    int              idx;
    pick = 3'd0;
    for (int k = NREQ; k >= 1; k--) begin
      idx  = int'(last) + k;
      idx  = (idx >= NREQ) ? (idx - NREQ) : idx;
      rot  = r >> idx;
      pick = rot[0] ? 3'(idx) : pick;
    end
    return pick;
  endfunction
`endif

  // Pick the arbitration winner and extract its command fields.
  always_comb begin
`ifdef GPIO_ARB_FIXED_PRI_EN
    win_s = fixed_pick(req);
`else
    win_s = rr_pick(req, last_gnt_r);
`endif
    any_req_s   = |req;
    we_sh_s     = we >> win_s;
    sel_sh_s    = sel >> {win_s, 1'b0};
    wdata_sh_s  = wdata >> {win_s, 3'b000};
    win_we_s    = we_sh_s[0];
    win_sel_s   = sel_sh_s[1:0];
    win_wdata_s = wdata_sh_s[7:0];
    grant_oh_s  = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
    wr_err_s    = cmd_we_r & (cmd_sel_r < 2'b10);
  end

  // Sequencer: grant, drive the GPIO port, capture read data, acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_we_r    <= 1'b0;
      cmd_sel_r   <= 2'b00;
      ack         <= '0;
      rdata       <= 8'h00;
      err         <= 1'b0;
      busy        <= 1'b0;
      gnt_id      <= 3'd0;
      gpio_busw   <= 1'b0;
      gpio_regsel <= 2'b00;
      gpio_wdata  <= 8'h00;
`ifndef GPIO_ARB_FIXED_PRI_EN
      last_gnt_r  <= 3'(NREQ - 1);
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack <= '0;
          err <= 1'b0;
          if (any_req_s) begin
            state_r     <= ST_ISSUE;
            busy        <= 1'b1;
            gnt_id      <= win_s;
            cmd_we_r    <= win_we_s;
            cmd_sel_r   <= win_sel_s;
            gpio_busw   <= win_we_s;
            gpio_regsel <= win_sel_s;
            gpio_wdata  <= win_wdata_s;
`ifndef GPIO_ARB_FIXED_PRI_EN
            last_gnt_r  <= win_s;
`endif
          end else begin
            state_r     <= ST_IDLE;
            busy        <= 1'b0;
            gpio_busw   <= 1'b0;
            gpio_regsel <= 2'b00;
            gpio_wdata  <= 8'h00;
          end
        end

        ST_ISSUE: begin
          if (cmd_we_r) begin
            // Writes complete here; writes to the read-only PIN slots are
            // still forwarded (GPIO ignores them) but flagged with err.
            state_r     <= ST_RESP;
            ack         <= grant_oh_s;
            err         <= wr_err_s;
            rdata       <= 8'h00;
            gpio_busw   <= 1'b0;
            gpio_regsel <= 2'b00;
            gpio_wdata  <= 8'h00;
          end else begin
            // GPIO registers its read data at the end of ISSUE, so keep the
            // select steady for one more cycle and capture next.
            state_r     <= ST_CAPTURE;
            gpio_busw   <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          state_r     <= ST_RESP;
          ack         <= grant_oh_s;
          err         <= 1'b0;
          rdata       <= gpio_rdata;
          gpio_busw   <= 1'b0;
          gpio_regsel <= 2'b00;
          gpio_wdata  <= 8'h00;
        end

        ST_RESP: begin
          state_r     <= ST_IDLE;
          ack         <= '0;
          err         <= 1'b0;
          busy        <= 1'b0;
          gpio_busw   <= 1'b0;
          gpio_regsel <= 2'b00;
          gpio_wdata  <= 8'h00;
        end

        default: begin
          state_r     <= ST_IDLE;
          ack         <= '0;
          err         <= 1'b0;
          busy        <= 1'b0;
          gpio_busw   <= 1'b0;
          gpio_regsel <= 2'b00;
          gpio_wdata  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Round-robin arbiter and sequencer that shares the single GPIO register port (BUSW / BUSWDATA / BUSRDATA / REGSEL) among NREQ requesters, such as the APB slave bridge and on-chip masters. It grants one requester at a time and drives the GPIO port with the correct write and read timing. It returns read data and a one-cycle acknowledge to the granted requester. It sits between the requesters and the GPIO instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high until its ack
- we  in  NREQ  per-requester write (1) / read (0)
- sel  in  2*NREQ  per-requester register select, slice i = sel[2i+1:2i]
- wdata  in  8*NREQ  per-requester write data, slice i = wdata[8i+7:8i]
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rdata  out  8  read data, valid while ack is high
- err  out  1  high with ack when a write targeted sel 2'b00/2'b01 (read-only PIN)
- busy  out  1  high in any state other than IDLE
- gnt_id  out  3  index of the current or last granted requester
- gpio_busw  out  1  to GPIO BUSW
- gpio_regsel  out  2  to GPIO REGSEL
- gpio_wdata  out  8  to GPIO BUSWDATA
- gpio_rdata  in  8  from GPIO BUSRDATA (registered in GPIO)

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req is high, pick the winner, latch its we, sel and wdata into command registers, set gnt_id, and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration: round-robin. The search starts at last_gnt+1 and wraps modulo NREQ. last_gnt updates on each grant.
- ISSUE (1 cycle):
  - gpio_regsel = latched sel. gpio_busw = latched we. gpio_wdata = latched wdata.
  - Write: go to RESP.
  - Read: go to CAPTURE.
- CAPTURE (reads only, 1 cycle):
  - gpio_busw = 0 and gpio_regsel is held.
  - At the end of the cycle, register gpio_rdata into rdata. Go to RESP.
- RESP (1 cycle):
  - ack[gnt_id] = 1. rdata is valid for reads and 8'h00 for writes.
  - err = we & (sel < 2'b10). The write is still forwarded to GPIO, which ignores it.
  - Go to IDLE.
- Requester rules:
  - A requester must keep we, sel and wdata stable while req is high.
  - It deasserts req at the edge after it sees ack. A req still high in the following IDLE cycle is a new request.
- Outside ISSUE and CAPTURE: gpio_busw = 0, gpio_regsel = 2'b00, gpio_wdata = 8'h00.
- req bits that drop before a grant are ignored. No ack is produced for them.

## Timing
- Reset values:
  - state = IDLE, ack = 0, rdata = 8'h00, err = 0, busy = 0, gnt_id = 0.
  - gpio_busw = 0, gpio_regsel = 2'b00, gpio_wdata = 8'h00.
  - last_gnt = NREQ-1, so requester 0 wins first.
- Write: req sampled in IDLE at edge T, ISSUE during cycle T+1, ack during T+2. Three cycles per write including IDLE.
- Read: ISSUE during T+1, CAPTURE during T+2, ack during T+3. Four cycles per read.
- Back-to-back requests from different requesters always have one IDLE cycle between them.
- Simultaneous requests: exactly one grant per IDLE cycle. The losers wait. Worst-case wait is NREQ-1 transactions.
- Reset asserted mid-transaction:
  - Go to IDLE immediately with reset output values. No ack is issued.
  - A write already presented in ISSUE may have been taken by the GPIO.
- All outputs are registered.

## Configuration
- GPIO_ARB_FIXED_PRI_EN
  - Defined: fixed priority, where the lowest index wins. last_gnt is not used.
  - Undefined (default): round-robin as described above.
  - State machine and timing are identical in both cases.

## Test plan
- Reset, then requester 0 writes sel=2'b10, wdata=8'hA5 → ISSUE shows gpio_busw=1, gpio_regsel=2'b10, gpio_wdata=8'hA5; ack[0] two cycles after the grant edge; err=0.
- Requester 2 reads sel=2'b11 after PORT=8'h3C was written → gpio_busw=0 in ISSUE and CAPTURE; ack[2] with rdata=8'h3C three cycles after the grant edge.
- req=4'b1111 held, each requester re-requesting after its ack → grant order 0,1,2,3,0. With GPIO_ARB_FIXED_PRI_EN: 0,0,0 while req[0] stays high.
- Requester 1 writes sel=2'b00 → ack[1] with err=1; GPIO DIR and PORT unchanged.
- rst asserted during CAPTURE of a read → next cycle is IDLE with ack=0, rdata=8'h00, busy=0. The next grant goes to requester 0.
- Requester 3 raises req for one cycle while requester 0 is being serviced, then drops it → requester 3 receives no ack and the arbiter returns to IDLE.
